mudi_issue_ctrl: RTL and testbench

- Issue and hazard controller for the pipeline's multiply/divide unit (HI/LO unit).
- Sits between the E stage and the unit:
  - decides when a HI/LO-class instruction in E may fire the unit's start strobe;
  - tracks the unit's busy window with its own latency counter;
  - raises the D-stage stall for any HI/LO-touching instruction while the unit is started or busy.
- Single writer of the unit's start and op inputs.

---
 rtl/mudi_issue_ctrl.sv | 113 +++++++++++
 tb/tb_mudi_issue_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mudi_issue_ctrl.sv
// Issue/hazard controller for the HI/LO multiply-divide unit: fires the start strobe, tracks the busy window, raises the D stall.
// Optional build macro MUDI_DIVZERO_SKIP_EN: a zero-divisor div/divu/fdiv is dropped and flagged on divzero.
module mudi_issue_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int FDIV_LAT = 3,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_req,
  input  logic [2:0]  E_mudiOp,
  input  logic [31:0] E_src2,
  input  logic        D_isMudi,
  input  logic        E_flush,
  output logic        MUDI_start,
  output logic [2:0]  MUDI_mudiOp,
  output logic        isBusy,
  output logic        D_stall,
  output logic        done,
`ifdef MUDI_DIVZERO_SKIP_EN
  output logic        divzero,
`endif
  output logic        err_overlap
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               req_ok;
  logic               fire;
  logic [CNT_W-1:0]   op_lat;

  always_comb begin
    op_lat = '0;
    case (E_mudiOp)
      3'd0, 3'd1: op_lat = CNT_W'(MULT_LAT);
      3'd2, 3'd3: op_lat = CNT_W'(DIV_LAT);
      3'd6:       op_lat = CNT_W'(FDIV_LAT);
      default:    op_lat = '0;
    endcase
  end

  // A request may only issue from IDLE; op 7 is ignored entirely.
  assign req_ok = E_req && !E_flush && (E_mudiOp != 3'd7) && (state_q == IDLE) && !reset;

`ifdef MUDI_DIVZERO_SKIP_EN
  logic is_div;
  logic dz;
  assign is_div  = (E_mudiOp == 3'd2) || (E_mudiOp == 3'd3) || (E_mudiOp == 3'd6);
  assign dz      = req_ok && is_div && (E_src2 == 32'd0);
  assign fire    = req_ok && !dz;
  assign divzero = dz;
`else
  logic unused_src2;
  assign unused_src2 = ^E_src2;
  assign fire        = req_ok;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = err_q | (E_req && (E_mudiOp != 3'd7) && (state_q == RUN));
    case (state_q)
      IDLE: begin
        // mthi/mtlo have zero latency and leave the controller idle.
        if (fire && (op_lat != '0)) begin
          cnt_d   = op_lat;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    MUDI_start  = fire;
    MUDI_mudiOp = E_mudiOp;
    isBusy      = (cnt_q != '0);
    D_stall     = D_isMudi && (fire || isBusy);
    done        = done_q;
    err_overlap = err_q;
  end

endmodule

// File: tb/tb_mudi_issue_ctrl.sv
// Bench for mudi_issue_ctrl: directed steps then random traffic, checked every cycle against a cycle-indexed busy-window model.
module tb_mudi_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_req;
  logic [2:0]  E_mudiOp;
  logic [31:0] E_src2;
  logic        D_isMudi;
  logic        E_flush;
  logic        MUDI_start;
  logic [2:0]  MUDI_mudiOp;
  logic        isBusy;
  logic        D_stall;
  logic        done;
  logic        err_overlap;
`ifdef MUDI_DIVZERO_SKIP_EN
  logic        divzero;
`endif

  always #5 clk = ~clk;

  mudi_issue_ctrl dut (
    .clk(clk), .reset(reset), .E_req(E_req), .E_mudiOp(E_mudiOp), .E_src2(E_src2),
    .D_isMudi(D_isMudi), .E_flush(E_flush), .MUDI_start(MUDI_start),
    .MUDI_mudiOp(MUDI_mudiOp), .isBusy(isBusy), .D_stall(D_stall), .done(done),
`ifdef MUDI_DIVZERO_SKIP_EN
    .divzero(divzero),
`endif
    .err_overlap(err_overlap)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: the unit is busy on every cycle index <= busy_until; done pulses on cycle done_at.
  int cyc        = 0;
  int busy_until = -1;
  int done_at    = -1;
  bit m_err      = 1'b0;

  function automatic int lat_of(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd1) return 5;
    if (op == 3'd2 || op == 3'd3) return 10;
    if (op == 3'd6) return 3;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input bit rq, input logic [2:0] op, input logic [31:0] s2,
                      input bit dm, input bit fl, input bit rs, input bit chk);
    bit busy, go, dz;
    int L;
    @(negedge clk);
    reset = rs; E_req = rq; E_mudiOp = op; E_src2 = s2; D_isMudi = dm; E_flush = fl;
    #1;
    busy = (cyc <= busy_until);
    go   = !rs && rq && !fl && (op != 3'd7) && !busy;
    dz   = 1'b0;
`ifdef MUDI_DIVZERO_SKIP_EN
    if (go && (op == 3'd2 || op == 3'd3 || op == 3'd6) && s2 == 32'd0) begin
      dz = 1'b1;
      go = 1'b0;
    end
`endif
    if (chk) begin
      check("start",   {31'd0, MUDI_start},  {31'd0, go});
      check("op",      {29'd0, MUDI_mudiOp}, {29'd0, op});
      check("busy",    {31'd0, isBusy},      {31'd0, busy});
      check("stall",   {31'd0, D_stall},     {31'd0, dm && (go || busy)});
      check("done",    {31'd0, done},        {31'd0, (cyc == done_at)});
      check("err",     {31'd0, err_overlap}, {31'd0, m_err});
`ifdef MUDI_DIVZERO_SKIP_EN
      check("divzero", {31'd0, divzero},     {31'd0, dz});
`endif
    end
    @(posedge clk);
    if (rs) begin
      busy_until = cyc;
      done_at    = -1;
      m_err      = 1'b0;
    end else begin
      if (rq && op != 3'd7 && busy) m_err = 1'b1;
      if (go) begin
        L = lat_of(op);
        if (L > 0) begin
          busy_until = cyc + L;
          done_at    = cyc + L + 1;
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n, input bit dm);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd1, dm, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; E_req = 1'b0; E_mudiOp = 3'd0; E_src2 = 32'd1; D_isMudi = 1'b0; E_flush = 1'b0;

    // Reset two cycles; the first is before any edge so state is still unknown.
    step(1'b0, 3'd0, 32'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 3'd0, 32'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1, 1'b0);

    // mult with D_isMudi held high: stall on start cycle plus 5 busy cycles, done on cycle 6.
    step(1'b1, 3'd0, 32'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(7, 1'b1);

    // div, then fdiv issued on the done cycle.
    step(1'b1, 3'd2, 32'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(10, 1'b1);
    step(1'b1, 3'd6, 32'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(5, 1'b0);

    // mthi then mtlo back to back.
    step(1'b1, 3'd4, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);

    // divu interrupted by reset on busy cycle 4, then a multu.
    step(1'b1, 3'd3, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);
    step(1'b0, 3'd0, 32'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1, 1'b1);
    step(1'b1, 3'd1, 32'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(7, 1'b0);

    // Flushed request, op 7, then overlap error during RUN.
    step(1'b1, 3'd0, 32'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 3'd7, 32'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'd0, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    step(1'b1, 3'd2, 32'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(8, 1'b0);

    // Zero divisor: skipped when the option is built in, full latency otherwise.
    step(1'b1, 3'd2, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(12, 1'b1);
    step(1'b1, 3'd2, 32'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(12, 1'b1);
    step(1'b0, 3'd0, 32'd1, 1'b0, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 500; i++) begin
      bit          rq, fl, dm, rs;
      logic [2:0]  op;
      logic [31:0] s2;
      rq = ($urandom_range(0, 99) < 40);
      fl = ($urandom_range(0, 99) < 15);
      dm = $urandom_range(0, 1) == 1;
      rs = ($urandom_range(0, 99) < 3);
      op = 3'($urandom_range(0, 7));
      s2 = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      step(rq, op, s2, dm, fl, rs, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
